// File: rtl/kamacore_pkg.sv
// Shared core definitions: data width, opcode map and per-opcode operand usage.
package kamacore_pkg;

    localparam int unsigned CPU_WIDTH = 32;

    localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } opnd_use_t;

    // Unknown opcodes read nothing and write nothing.
    function automatic opnd_use_t decode_use(input logic [6:0] opcode);
        opnd_use_t u;
        u = '0;
        case (opcode)
            OPCODE_R_TYPE: u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
            OPCODE_I_TYPE: u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
            OPCODE_LOAD:   u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
            OPCODE_STORE:  u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
            OPCODE_BRANCH: u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
            OPCODE_LUI:    u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
            OPCODE_AUIPC:  u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
            OPCODE_JAL:    u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
            OPCODE_JALR:   u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
            default:       u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/kamacore_regfile.sv
// Integer register file: two combinational read ports with same-cycle write bypass,
// one synchronous write port, x0 hardwired to zero.
module kamacore_regfile
    import kamacore_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  reg_idx_t             i_raddr1,
    input  reg_idx_t             i_raddr2,
    output logic [CPU_WIDTH-1:0] o_rdata1,
    output logic [CPU_WIDTH-1:0] o_rdata2,
    input  logic                 i_we,
    input  reg_idx_t             i_waddr,
    input  logic [CPU_WIDTH-1:0] i_wdata
);

    logic [CPU_WIDTH-1:0] r_mem [NUM_REGS];
    logic                 w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = r_mem[i_raddr1];
        if (i_raddr1 == '0) begin
            o_rdata1 = '0;
        end else if (w_wr_en && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = r_mem[i_raddr2];
        if (i_raddr2 == '0) begin
            o_rdata2 = '0;
        end else if (w_wr_en && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/kamacore_decode_stage.sv
// Decode/operand-fetch stage: register read, RAW scoreboard stall, one-entry output
// bundle towards execute.
module kamacore_decode_stage
    import kamacore_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_if_valid,
    output logic                 o_if_ready,
    input  logic [CPU_WIDTH-1:0] i_if_instruction,
    input  logic [CPU_WIDTH-1:0] i_if_pc,
    output logic                 o_ex_valid,
    input  logic                 i_ex_ready,
    output logic [CPU_WIDTH-1:0] o_ex_instruction,
    output logic [CPU_WIDTH-1:0] o_ex_pc,
    output logic [CPU_WIDTH-1:0] o_ex_source1,
    output logic [CPU_WIDTH-1:0] o_ex_source2,
    output reg_idx_t             o_ex_rd,
    output logic                 o_ex_rd_we,
    input  logic                 i_wb_valid,
    input  logic                 i_wb_we,
    input  reg_idx_t             i_wb_rd,
    input  logic [CPU_WIDTH-1:0] i_wb_data,
    input  logic                 i_flush
);

    logic                 r_ex_valid;
    logic [CPU_WIDTH-1:0] r_ex_instruction;
    logic [CPU_WIDTH-1:0] r_ex_pc;
    logic [CPU_WIDTH-1:0] r_ex_source1;
    logic [CPU_WIDTH-1:0] r_ex_source2;
    reg_idx_t             r_ex_rd;
    logic                 r_ex_rd_we;
    logic [NUM_REGS-1:0]  r_pending;

    logic [6:0]           w_opcode;
    reg_idx_t             w_rs1;
    reg_idx_t             w_rs2;
    reg_idx_t             w_rd;
    opnd_use_t            w_use;
    logic [CPU_WIDTH-1:0] w_rdata1;
    logic [CPU_WIDTH-1:0] w_rdata2;
    logic                 w_busy1;
    logic                 w_busy2;
    logic                 w_hazard;
    logic                 w_accept;
    logic                 w_handoff;
    logic [NUM_REGS-1:0]  w_pending_d;

    assign w_opcode = i_if_instruction[6:0];
    assign w_rd     = i_if_instruction[11:7];
    assign w_rs1    = i_if_instruction[19:15];
    assign w_rs2    = i_if_instruction[24:20];
    assign w_use    = decode_use(w_opcode);

    kamacore_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (i_wb_valid && i_wb_we),
        .i_waddr  (i_wb_rd),
        .i_wdata  (i_wb_data)
    );

    // A register is busy if an older writer is outstanding downstream (unless it retires
    // right now) or is the writer currently sitting in this stage.
    assign w_busy1 = (r_pending[w_rs1] && !(i_wb_valid && (i_wb_rd == w_rs1))) ||
                     (r_ex_valid && r_ex_rd_we && (r_ex_rd == w_rs1));
    assign w_busy2 = (r_pending[w_rs2] && !(i_wb_valid && (i_wb_rd == w_rs2))) ||
                     (r_ex_valid && r_ex_rd_we && (r_ex_rd == w_rs2));
    assign w_hazard = (w_use.rs1 && (w_rs1 != '0) && w_busy1) ||
                      (w_use.rs2 && (w_rs2 != '0) && w_busy2);

    assign o_if_ready = i_rst_n && !i_flush && !w_hazard && (!r_ex_valid || i_ex_ready);
    assign w_accept   = i_if_valid && o_if_ready;
    assign w_handoff  = r_ex_valid && i_ex_ready && !i_flush;

    // Clear before set so a handoff wins over a same-cycle retire of the same register.
    always_comb begin
        w_pending_d = r_pending;
        if (i_wb_valid) begin
            w_pending_d[i_wb_rd] = 1'b0;
        end
        if (w_handoff && r_ex_rd_we) begin
            w_pending_d[r_ex_rd] = 1'b1;
        end
        w_pending_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ex_valid       <= 1'b0;
            r_ex_instruction <= '0;
            r_ex_pc          <= '0;
            r_ex_source1     <= '0;
            r_ex_source2     <= '0;
            r_ex_rd          <= '0;
            r_ex_rd_we       <= 1'b0;
            r_pending        <= '0;
        end else begin
            r_pending <= w_pending_d;
            if (i_flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_accept) begin
                r_ex_valid       <= 1'b1;
                r_ex_instruction <= i_if_instruction;
                r_ex_pc          <= i_if_pc;
                r_ex_source1     <= w_use.rs1 ? w_rdata1 : '0;
                r_ex_source2     <= w_use.rs2 ? w_rdata2 : '0;
                r_ex_rd          <= w_rd;
                r_ex_rd_we       <= w_use.rd && (w_rd != '0);
            end else if (w_handoff) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign o_ex_valid       = r_ex_valid;
    assign o_ex_instruction = r_ex_instruction;
    assign o_ex_pc          = r_ex_pc;
    assign o_ex_source1     = r_ex_source1;
    assign o_ex_source2     = r_ex_source2;
    assign o_ex_rd          = r_ex_rd;
    assign o_ex_rd_we       = r_ex_rd_we;

endmodule
